// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: bundles the two requester handshakes (instruction fetch and data
// access) and the single-port memory command/response bus seen by
// mem_port_arbiter.
//
// Signals:
//   if_req / if_addr              fetch request (level) and word address
//   if_ready / if_rdata           fetch completion pulse and fetched word
//   dm_req / dm_we / dm_addr      data request, write flag, word address
//   dm_wdata / dm_be              write data and byte enables
//   dm_ready / dm_rdata           data completion pulse and read word
//   mem_en / mem_we / mem_addr    memory command strobe, write, address
//   mem_wdata / mem_be            memory write data and byte enables
//   mem_rdata                     memory read data (fixed latency)
//
// Modports:
//   slave  - the arbiter's view
//   master - the pipeline / memory side view
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [3:0]        dm_be;
    logic              dm_ready;
    logic [31:0]       dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_ready, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_ready, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares one single-port, fixed-latency memory between the
// instruction fetch (IF) and MEM-stage data (DM) requesters. One transaction
// is in flight at a time; DM wins ties because it belongs to the older
// instruction. Reads wait LAT cycles for mem_rdata, writes are posted.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-low reset
//   bus   slave modport of mem_port_arbiter_if (requesters + memory bus)
//   busy  out  high whenever the FSM is not IDLE
//
// Optional feature (macro ARB_STARVE_GUARD_EN): after MAX_DM_STREAK
// consecutive DM grants made while IF was waiting, the next contested grant
// goes to IF. With the macro undefined DM priority is strict.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int LAT           = 2,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int CNT_W = $clog2(LAT + 1);

    if (LAT < 1 || MAX_DM_STREAK < 1) begin : g_param_check
        $error("mem_port_arbiter: LAT and MAX_DM_STREAK must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;        // 0 = IF, 1 = DM
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;

    logic force_if;
    logic dm_grant;
    logic if_grant;

    // Grant decisions are only meaningful in IDLE; the starvation guard can
    // override DM priority only when IF is actually waiting.
    assign dm_grant = (state_q == IDLE) && bus.dm_req && !(force_if && bus.if_req);
    assign if_grant = (state_q == IDLE) && bus.if_req && !dm_grant;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STRK_W = $clog2(MAX_DM_STREAK + 1);

    logic [STRK_W-1:0] streak_q, streak_d;

    assign force_if = (streak_q == STRK_W'(MAX_DM_STREAK));

    // A DM grant with IF waiting is never forced, so the streak tops out at
    // MAX_DM_STREAK and cannot wrap.
    always_comb begin
        streak_d = streak_q;
        if (if_grant) begin
            streak_d = '0;
        end else if (dm_grant && bus.if_req) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (dm_grant) begin
                    gnt_d   = 1'b1;
                    we_d    = bus.dm_we;
                    addr_d  = bus.dm_addr;
                    wdata_d = bus.dm_wdata;
                    be_d    = bus.dm_be;
                    state_d = ISSUE;
                end else if (if_grant) begin
                    gnt_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = bus.if_addr;
                    be_d    = 4'b1111;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    // Posted write: nothing comes back from the memory.
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (gnt_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // Requests seen here are deliberately ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Strobes are asserted only in ISSUE; address and write data simply
    // hold the last command between transactions.
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) && we_q;
    assign bus.mem_be    = (state_q == ISSUE) ? be_q : 4'b0000;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_ready  = (state_q == DONE) && !gnt_q;
    assign bus.dm_ready  = (state_q == DONE) && gnt_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;

    assign busy = (state_q != IDLE);
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences one shared single-port, fixed-latency memory between two requesters: instruction fetch (IF) and the MEM-stage data access (DM).
- Sits between the pipeline and the unified memory macro.
- Drives per-requester ready pulses; the pipeline uses these to derive its PC/IF-ID and MEM stall signals.
- Data requests have priority over fetch by default, because they belong to the older instruction.

Parameters:
ADDR_W, 10, word-address width.
LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata (LAT >= 1).
MAX_DM_STREAK, 4, consecutive DM grants allowed before IF is forced (used only with the optional feature).

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset.
if_req  in  1  fetch request; level signal, held until if_ready.
if_addr  in  ADDR_W  fetch word address; stable while if_req is high.
if_ready  out  1  one-cycle pulse; fetch complete.
if_rdata  out  32  fetched word; valid with if_ready and held until the next if_ready.
dm_req  in  1  data request; level signal, held until dm_ready.
dm_we  in  1  1 = write, 0 = read.
dm_addr  in  ADDR_W  data word address.
dm_wdata  in  32  write data.
dm_be  in  4  byte enables for writes.
dm_ready  out  1  one-cycle pulse; data access complete.
dm_rdata  out  32  read word; valid with dm_ready and held until the next dm_ready.
mem_en  out  1  memory command strobe; one cycle per transaction.
mem_we  out  1  memory write.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  32  memory write data.
mem_be  out  4  memory byte enables.
mem_rdata  in  32  memory read data; valid LAT cycles after mem_en.
busy  out  1  high in every state except IDLE.

Behaviour:
- Registered FSM with states IDLE, ISSUE, WAIT, DONE. The grant register gnt is 0 for IF and 1 for DM. Latency counter cnt has width clog2(LAT+1).
- IDLE:
  - dm_req=1: gnt<=DM, then go to ISSUE.
  - else if_req=1: gnt<=IF, then go to ISSUE.
  - Neither request: stay in IDLE.
  - The granted request's address, data, we and be are captured into command registers at this same edge.
- ISSUE (exactly 1 cycle):
  - mem_en=1 and the command registers drive mem_*.
  - IF commands always use mem_we=0 and mem_be=4'b1111.
  - DM write: go to DONE (posted write, no wait).
  - Read: cnt<=LAT-1 and go to WAIT.
- WAIT: decrement cnt each cycle. When cnt==0, capture mem_rdata into the granted requester's rdata register and go to DONE.
  - For LAT=1, WAIT lasts exactly 1 cycle and captures in that cycle.
- DONE (1 cycle): pulse the granted requester's ready, then go to IDLE. Any req seen in the DONE cycle is ignored; arbitration resumes in the IDLE cycle that follows.
- Timing:
  - Read: the request first seen in IDLE cycle A gives mem_en in cycle A+1 and ready in cycle A+2+LAT.
  - Write: the request first seen in IDLE cycle A gives mem_en in cycle A+1 and ready in cycle A+2.
- Outside ISSUE: mem_en=0, mem_we=0, mem_be=0. mem_addr and mem_wdata hold their last values.
- At most one transaction is outstanding at a time. The ready outputs are mutually exclusive.
- Simultaneous if_req and dm_req in IDLE: DM wins. IF stays pending and is served in the next IDLE cycle if dm_req has dropped.
- A requester dropping req mid-transaction is ignored; the transaction completes and its ready still pulses.
- Reset (rst=0 at an edge), from any state including mid-transaction:
  - Next state is IDLE; any transaction in flight is aborted and no ready is ever issued for it.
  - All outputs return to 0: if_ready, dm_ready, if_rdata, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy.
  - gnt and cnt are cleared, and the streak counter is cleared.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A streak counter increments on each DM grant made while if_req=1 and clears on any IF grant.
  - When the streak equals MAX_DM_STREAK and both requests are present in IDLE, IF is granted.
- Undefined: strict DM priority; the streak counter is not built.

Test Plan:
- IF read, LAT=2: if_req=1, if_addr=0x010 first seen in IDLE cycle 0; memory model returns 0x12345678 → mem_en=1 with mem_addr=0x010 and mem_we=0 in cycle 1; if_ready=1 and if_rdata=0x12345678 in cycle 4; busy=0 in cycle 5.
- Collision: if_req and dm_req (read, addr 0x020) both rise in cycle 0 → DM mem_en in cycle 1, dm_ready in cycle 4; IF mem_en in cycle 6, if_ready in cycle 9.
- DM write: dm_we=1, dm_be=4'b0011, dm_wdata=0xCAFEBABE, addr 0x3FF → one mem_en cycle with mem_we=1, mem_be=0011, mem_wdata=0xCAFEBABE; dm_ready on the next cycle; no WAIT state.
- Reset during WAIT: rst=0 for 1 cycle → next cycle all outputs are 0 and the state is IDLE; no ready pulse follows; a new request after reset completes normally.
- Starvation: dm_req and if_req held high continuously.
  - Macro defined, MAX_DM_STREAK=4: 4 dm_ready pulses, then 1 if_ready, then the pattern repeats.
  - Macro undefined: 0 if_ready pulses across 20 transactions.
- LAT=1: read data 0xA5A5A5A5 → mem_en in cycle A+1, ready in cycle A+3, rdata=0xA5A5A5A5.
